// File: rtl/vme_slave_cycle.sv
// ---------------------------------------------------------------------------
// vme_slave_cycle
//   Data-cycle engine that sits behind the VME address decoder. It runs one
//   A16 D08(O) slave transfer per data strobe: it synchronises XDS[0], XAS and
//   XWRITE, gives the local register file a one-clock read or write strobe,
//   then drives the data bus, the transceiver direction and DTACK. DTACK is
//   driven high for a few clocks before its driver is released.
//
// Ports
//   CPLDCLK     system clock, rising edge
//   CRST        synchronous active-high reset
//   ADDR_MATCH  decoder hit, level, valid while XAS is low
//   XAS, XDS    VME address / data strobes, active low, asynchronous
//   XWRITE      VME write, active low
//   XA, XD_IN   register sub-address and VME data in
//   XD_OUT      read data to the bus; XD_OE enables it
//   DDIR        transceiver direction, 1 = board->VME
//   XDTACK      DTACK level, active low; XDTACKOE enables its driver (active low)
//   REG_*       local register-file interface (address, write data,
//               one-clock strobes, read data valid the cycle after REG_RE)
//   BUS_STUCK   one-clock pulse when DS is not released within TIMEOUT cycles
// ---------------------------------------------------------------------------
module vme_slave_cycle #(
   parameter int ADDR_W      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int DTACK_DELAY = 2,
   parameter int RELEASE_CYC = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic              CPLDCLK,
   input  logic              CRST,
   input  logic              ADDR_MATCH,
   input  logic              XAS,
   input  logic [1:0]        XDS,
   input  logic              XWRITE,
   input  logic [ADDR_W-1:0] XA,
   input  logic [7:0]        XD_IN,
   output logic [7:0]        XD_OUT,
   output logic              XD_OE,
   output logic              DDIR,
   output logic              XDTACK,
   output logic              XDTACKOE,
   output logic [ADDR_W-1:0] REG_ADDR,
   output logic [7:0]        REG_WDATA,
   output logic              REG_WE,
   output logic              REG_RE,
   input  logic [7:0]        REG_RDATA,
   output logic              BUS_STUCK
);

   localparam int WCNT_W = (DTACK_DELAY > 1) ? $clog2(DTACK_DELAY) : 1;
   localparam int RCNT_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_ACCESS, ST_WAIT, ST_ACK, ST_RELEASE, ST_ABORT
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ds_sync_q, ds_sync_d;
   logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
   logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
   logic [WCNT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic [RCNT_W-1:0]      rel_cnt_q, rel_cnt_d;
   logic [7:0]             tmo_cnt_q, tmo_cnt_d;
   logic                   armed_q, armed_d;
   logic                   wr_q, wr_d;
   logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
   logic [7:0]             reg_wdata_q, reg_wdata_d;
   logic [7:0]             xd_out_q, xd_out_d;
   logic                   xd_oe_q, xd_oe_d;
   logic                   ddir_q, ddir_d;
   logic                   xdtack_q, xdtack_d;
   logic                   xdtackoe_q, xdtackoe_d;
   logic                   reg_we_q, reg_we_d;
   logic                   reg_re_q, reg_re_d;
   logic                   bus_stuck_q, bus_stuck_d;

   logic ds_n, as_n, wr_n;
   logic unused_xds1;

   assign ds_n        = ds_sync_q[SYNC_STAGES-1];
   assign as_n        = as_sync_q[SYNC_STAGES-1];
   assign wr_n        = wr_sync_q[SYNC_STAGES-1];
   assign unused_xds1 = XDS[1];

   // The DTACK/data-bus drivers are decoded from the current state, so they
   // trail the state register by one clock; the register strobes and the
   // BUS_STUCK pulse are decoded from the transition itself.
   always_comb begin
      // NOTE: every variable gets a default before the case; a path that
      // leaves one unassigned would infer a latch.
      state_d     = state_q;
      ds_sync_d   = {ds_sync_q[SYNC_STAGES-2:0], XDS[0]};
      as_sync_d   = {as_sync_q[SYNC_STAGES-2:0], XAS};
      wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], XWRITE};
      wait_cnt_d  = wait_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      // Re-arm on any clock that sees DS high, so one DS serves one access.
      armed_d     = armed_q | ds_n;
      wr_d        = wr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      xd_out_d    = xd_out_q;
      xd_oe_d     = xd_oe_q;
      ddir_d      = ddir_q;
      xdtack_d    = 1'b1;
      xdtackoe_d  = 1'b1;
      reg_we_d    = 1'b0;
      reg_re_d    = 1'b0;
      bus_stuck_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (armed_q && ADDR_MATCH && !as_n && !ds_n) begin
               state_d     = ST_ACCESS;
               armed_d     = 1'b0;
               reg_addr_d  = XA;
               reg_wdata_d = XD_IN;
               wr_d        = !wr_n;
               reg_we_d    = !wr_n;
               reg_re_d    = wr_n;
            end
         end
         ST_ACCESS: begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
         end
         ST_WAIT: begin
            if (as_n || ds_n) begin
               state_d = ST_ABORT;
            end else begin
               // REG_RDATA is valid now, one cycle after REG_RE.
               if (wait_cnt_q == '0 && !wr_q) begin
                  xd_out_d = REG_RDATA;
                  xd_oe_d  = 1'b1;
                  ddir_d   = 1'b1;
               end
               if (wait_cnt_q == WCNT_W'(DTACK_DELAY - 1)) begin
                  state_d   = ST_ACK;
                  tmo_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + WCNT_W'(1);
               end
            end
         end
         ST_ACK: begin
            xdtack_d   = 1'b0;
            xdtackoe_d = 1'b0;
            if (ds_n) begin
               state_d   = ST_RELEASE;
               rel_cnt_d = '0;
            end else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
               state_d     = ST_RELEASE;
               rel_cnt_d   = '0;
               bus_stuck_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         ST_RELEASE: begin
            // Drive DTACK high before tristating it so the line rises cleanly.
            xd_oe_d    = 1'b0;
            ddir_d     = 1'b0;
            xdtackoe_d = 1'b0;
            if (rel_cnt_q == RCNT_W'(RELEASE_CYC - 1)) begin
               state_d = ST_IDLE;
            end else begin
               rel_cnt_d = rel_cnt_q + RCNT_W'(1);
            end
         end
         ST_ABORT: begin
            xd_oe_d = 1'b0;
            ddir_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge CPLDCLK) begin
      if (CRST) begin
         state_q     <= ST_IDLE;
         ds_sync_q   <= '1;
         as_sync_q   <= '1;
         wr_sync_q   <= '1;
         wait_cnt_q  <= '0;
         rel_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         armed_q     <= 1'b0;
         wr_q        <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         xd_out_q    <= '0;
         xd_oe_q     <= 1'b0;
         ddir_q      <= 1'b0;
         xdtack_q    <= 1'b1;
         xdtackoe_q  <= 1'b1;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         bus_stuck_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ds_sync_q   <= ds_sync_d;
         as_sync_q   <= as_sync_d;
         wr_sync_q   <= wr_sync_d;
         wait_cnt_q  <= wait_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         armed_q     <= armed_d;
         wr_q        <= wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         xd_out_q    <= xd_out_d;
         xd_oe_q     <= xd_oe_d;
         ddir_q      <= ddir_d;
         xdtack_q    <= xdtack_d;
         xdtackoe_q  <= xdtackoe_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         bus_stuck_q <= bus_stuck_d;
      end
   end

   assign XD_OUT    = xd_out_q;
   assign XD_OE     = xd_oe_q;
   assign DDIR      = ddir_q;
   assign XDTACK    = xdtack_q;
   assign XDTACKOE  = xdtackoe_q;
   assign REG_ADDR  = reg_addr_q;
   assign REG_WDATA = reg_wdata_q;
   assign REG_WE    = reg_we_q;
   assign REG_RE    = reg_re_q;
   assign BUS_STUCK = bus_stuck_q;

endmodule

// File: tb/tb_vme_slave_cycle.sv
// ---------------------------------------------------------------------------
// tb_vme_slave_cycle
//   Drives single VME data cycles (directed corner cases, then random ones)
//   and compares every output on every clock against event times derived
//   from the transfer rules: strobe edge, capture edge, DTACK window,
//   release window, abort and timeout.
// ---------------------------------------------------------------------------
module tb_vme_slave_cycle;

   localparam int S = 2;    // synchroniser depth
   localparam int W = 2;    // WAIT cycles before DTACK
   localparam int R = 2;    // DTACK high-drive cycles
   localparam int T = 255;  // ACK timeout

   logic       CPLDCLK = 1'b0;
   logic       CRST = 1'b1;
   logic       ADDR_MATCH = 1'b0;
   logic       XAS = 1'b1;
   logic [1:0] XDS = 2'b11;
   logic       XWRITE = 1'b1;
   logic [2:0] XA = '0;
   logic [7:0] XD_IN = '0;
   logic [7:0] REG_RDATA = '0;
   logic [7:0] XD_OUT;
   logic       XD_OE, DDIR, XDTACK, XDTACKOE, REG_WE, REG_RE, BUS_STUCK;
   logic [2:0] REG_ADDR;
   logic [7:0] REG_WDATA;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CPLDCLK = ~CPLDCLK;

   vme_slave_cycle #(
      .ADDR_W(3), .SYNC_STAGES(S), .DTACK_DELAY(W), .RELEASE_CYC(R), .TIMEOUT(T)
   ) dut (
      .CPLDCLK(CPLDCLK), .CRST(CRST), .ADDR_MATCH(ADDR_MATCH), .XAS(XAS),
      .XDS(XDS), .XWRITE(XWRITE), .XA(XA), .XD_IN(XD_IN),
      .XD_OUT(XD_OUT), .XD_OE(XD_OE), .DDIR(DDIR), .XDTACK(XDTACK),
      .XDTACKOE(XDTACKOE), .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA),
      .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_RDATA(REG_RDATA),
      .BUS_STUCK(BUS_STUCK)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One data cycle. Edge n=0 is the first edge that samples XDS[0] low;
   // DS stays low for l_low edges. rst_at >= 0 pulses CRST on that edge.
   task automatic run_txn(input int id, input bit match, input bit is_wr,
                          input logic [2:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rdata, input int l_low, input int rst_at);
      bit   acc, abort_c, cap, stuck, in_rst;
      int   a, b, e, k, n_end, last;
      logic e_we, e_re, e_dtack, e_dtackoe, e_oe, e_stuck;
      string p;

      acc     = match;
      a       = S;                       // edge that enters ACCESS
      e       = a + W + 1;               // edge that enters ACK
      abort_c = acc && (l_low <= W + 1); // DS seen high during WAIT
      // Read data is captured only if DS is still low through the first WAIT cycle.
      cap     = acc && !is_wr && (l_low + S - 1 > a + 1);
      b       = ((a + 1 > l_low + S - 1) ? a + 1 : l_low + S - 1) + 1;
      stuck   = acc && !abort_c && (l_low + S > e + T);
      k       = stuck ? e + T : l_low + S; // edge that leaves ACK
      if (!acc)         last = 0;
      else if (abort_c) last = b;
      else              last = k + R;
      n_end = ((l_low > last) ? l_low : last) + S + R + 4;
      if (rst_at >= 0) n_end = rst_at + 6;

      for (int n = 0; n < n_end; n++) begin
         ADDR_MATCH = match;
         XWRITE     = !is_wr;
         XA         = addr;
         XD_IN      = wdata;
         XDS[0]     = (n < l_low) ? 1'b0 : 1'b1;
         XAS        = (n < l_low) ? 1'b0 : 1'b1;
         CRST       = (rst_at >= 0 && n == rst_at);
         REG_RDATA  = (cap && n == a + 2) ? rdata : 8'($urandom);
         @(posedge CPLDCLK);
         @(negedge CPLDCLK);

         e_we = acc && n == a && is_wr;
         e_re = acc && n == a && !is_wr;
         e_dtack = 1'b1; e_dtackoe = 1'b1; e_oe = 1'b0; e_stuck = 1'b0;
         if (acc && !abort_c) begin
            if (n >= e + 1 && n <= k)     e_dtack   = 1'b0;
            if (n >= e + 1 && n <= k + R) e_dtackoe = 1'b0;
            if (cap && n >= a + 2 && n <= k) e_oe   = 1'b1;
            if (stuck && n == k)          e_stuck   = 1'b1;
         end else if (abort_c) begin
            if (cap && n >= a + 2 && n <= b) e_oe = 1'b1;
         end
         in_rst = (rst_at >= 0) && (n >= rst_at);
         if (in_rst) begin
            e_we = 0; e_re = 0; e_dtack = 1; e_dtackoe = 1; e_oe = 0; e_stuck = 0;
         end

         p = $sformatf("t%0d n%0d", id, n);
         check({p, " reg_we"},    32'(REG_WE),    32'(e_we));
         check({p, " reg_re"},    32'(REG_RE),    32'(e_re));
         check({p, " xdtack"},    32'(XDTACK),    32'(e_dtack));
         check({p, " xdtackoe"},  32'(XDTACKOE),  32'(e_dtackoe));
         check({p, " xd_oe"},     32'(XD_OE),     32'(e_oe));
         check({p, " ddir"},      32'(DDIR),      32'(e_oe));
         check({p, " bus_stuck"}, 32'(BUS_STUCK), 32'(e_stuck));
         if (acc && n == a && !in_rst) begin
            check({p, " reg_addr"}, 32'(REG_ADDR), 32'(addr));
            if (is_wr) check({p, " reg_wdata"}, 32'(REG_WDATA), 32'(wdata));
         end
         if (cap && n == a + 2 && !in_rst)
            check({p, " xd_out"}, 32'(XD_OUT), 32'(rdata));
         if (rst_at >= 0 && n == rst_at) begin
            check({p, " rst xd_out"},    32'(XD_OUT),    32'h0);
            check({p, " rst reg_addr"},  32'(REG_ADDR),  32'h0);
            check({p, " rst reg_wdata"}, 32'(REG_WDATA), 32'h0);
         end
      end
      CRST = 1'b0;
   endtask

   initial begin
      int kind, len;
      CRST = 1'b1;
      repeat (3) @(posedge CPLDCLK);
      @(negedge CPLDCLK);
      check("reset xd_oe",     32'(XD_OE),     32'h0);
      check("reset ddir",      32'(DDIR),      32'h0);
      check("reset xdtack",    32'(XDTACK),    32'h1);
      check("reset xdtackoe",  32'(XDTACKOE),  32'h1);
      check("reset reg_we",    32'(REG_WE),    32'h0);
      check("reset reg_re",    32'(REG_RE),    32'h0);
      check("reset bus_stuck", 32'(BUS_STUCK), 32'h0);
      check("reset xd_out",    32'(XD_OUT),    32'h0);
      check("reset reg_addr",  32'(REG_ADDR),  32'h0);
      check("reset reg_wdata", 32'(REG_WDATA), 32'h0);
      CRST = 1'b0;

      run_txn(0, 1, 1, 3'd5, 8'hA7, 8'h00, 10,  -1); // write
      run_txn(1, 1, 0, 3'd2, 8'h00, 8'h3C, 10,  -1); // read
      run_txn(2, 0, 1, 3'd3, 8'h55, 8'h11, 6,   -1); // no decoder hit
      run_txn(3, 1, 0, 3'd1, 8'h00, 8'h99, 2,   -1); // read aborted in WAIT
      run_txn(4, 1, 0, 3'd6, 8'h00, 8'h77, 3,   -1); // read aborted after capture
      run_txn(5, 1, 1, 3'd6, 8'h12, 8'h00, 1,   -1); // write aborted, strobe kept
      run_txn(6, 1, 0, 3'd4, 8'h00, 8'hC3, 300, -1); // DS stuck low
      run_txn(7, 1, 1, 3'd7, 8'h5A, 8'h00, 9,    9); // reset during ACK
      run_txn(8, 1, 1, 3'd0, 8'hFF, 8'h00, W + 2, -1); // shortest non-abort DS

      for (int i = 9; i < 49; i++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 2)      len = int'($urandom_range(1, 12));
         else if (kind < 4) len = int'($urandom_range(1, W + 1));
         else               len = int'($urandom_range(W + 2, 20));
         run_txn(i, kind >= 2, 1'($urandom), 3'($urandom), 8'($urandom),
                 8'($urandom), len, -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
